// File: rtl/mfp_irq_ctrl.sv
// Vectored, priority-encoded interrupt controller for NUM_IRQ sources with per-channel
// polarity and edge/level select, MFP-style register banks and a vector latched on iack.
module mfp_irq_ctrl #(
  parameter int NUM_IRQ = 16,
  parameter int IDX_W   = $clog2(NUM_IRQ),
  parameter int NB      = NUM_IRQ / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic [7:0]         din,
  input  logic               sel,
  input  logic [4:0]         addr,
  input  logic               ds,
  input  logic               rw,
  output logic [7:0]         dout,
  output logic               dtack,
  input  logic [NUM_IRQ-1:0] src,
  output logic               irq,
  input  logic               iack
);
  typedef logic [NUM_IRQ-1:0] word_t;

  localparam logic [2:0] R_IER  = 3'd0;
  localparam logic [2:0] R_IPR  = 3'd1;
  localparam logic [2:0] R_ISR  = 3'd2;
  localparam logic [2:0] R_IMR  = 3'd3;
  localparam logic [2:0] R_AER  = 3'd4;
  localparam logic [2:0] R_MODE = 3'd5;
  localparam logic [2:0] R_VR   = 3'd7;

  word_t ier, ipr, isr, imr, aer, mode, s_d;
  logic [7:0] vr, vec;
  logic sel_d, iack_d;

  logic [2:0] rsel;
  logic [1:0] bank;
  logic       wr, rd_en, ack;
  word_t      lane, wdat, s, evt, pend, ipr_n, isr_n, rd_word;
  logic [7:0] rd_byte;
  logic [IDX_W:0]   p_top, s_top;
  logic [IDX_W-1:0] hp, hp_vec;

  // Highest set bit as index+1, so an empty vector (0) ranks below every real source.
  function automatic logic [IDX_W:0] top_bit(input word_t v);
    top_bit = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (v[i]) top_bit = (IDX_W+1)'(i + 1);
  endfunction

  assign rsel  = addr[4:2];
  assign bank  = addr[1:0];
  assign wr    = sel & ~sel_d & ~ds & ~rw;
  assign rd_en = sel & ~ds & rw;
  assign dtack = sel_d & sel;
  assign ack   = iack & ~iack_d;

  // Banks at or beyond NB shift the byte lane out of the word, so such writes touch nothing.
  assign lane = word_t'(8'hFF) << {bank, 3'b000};
  assign wdat = {NB{din}};

  assign s    = src ^ ~aer;
  assign evt  = s & (mode | ~s_d);
  assign pend = ipr & imr;

  assign p_top  = top_bit(pend);
  assign s_top  = top_bit(isr);
  assign hp     = IDX_W'(p_top - 1'b1);
  assign hp_vec = (pend != '0) ? hp : {IDX_W{1'b0}};
  assign irq    = p_top > s_top;

  always_comb begin
    ipr_n = ipr;
    isr_n = isr;
    if (wr && (rsel == R_IER || rsel == R_IPR)) ipr_n = ipr_n & (~lane | wdat);
    if (wr && rsel == R_ISR) isr_n = isr_n & (~lane | wdat);
    if (ack && pend != '0) begin
      ipr_n[hp] = 1'b0;
      if (vr[3]) isr_n[hp] = 1'b1;
    end
    // New events are applied last so they win over any clear in the same cycle.
    ipr_n = ipr_n | (evt & ier);
  end

  always_comb begin
    rd_word = '0;
    case (rsel)
      R_IER:   rd_word = ier;
      R_IPR:   rd_word = ipr;
      R_ISR:   rd_word = isr;
      R_IMR:   rd_word = imr;
      R_AER:   rd_word = aer;
      R_MODE:  rd_word = mode;
      default: rd_word = '0;
    endcase
    rd_byte = 8'h00;
    for (int b = 0; b < NB; b++)
      if (int'(bank) == b) rd_byte = rd_word[8*b +: 8];
    dout = 8'h00;
    if (rd_en)     dout = (rsel == R_VR) ? vr : rd_byte;
    else if (iack) dout = vec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ier    <= '0;
      ipr    <= '0;
      isr    <= '0;
      imr    <= '0;
      aer    <= '0;
      mode   <= '0;
      s_d    <= '0;
      vr     <= 8'h00;
      vec    <= 8'h00;
      sel_d  <= 1'b0;
      iack_d <= 1'b0;
    end else if (clk_en) begin
      sel_d  <= sel;
      iack_d <= iack;
      s_d    <= s;
      ipr    <= ipr_n;
      isr    <= isr_n;
      if (wr) begin
        case (rsel)
          R_IER:   ier  <= (ier & ~lane) | (wdat & lane);
          R_IMR:   imr  <= (imr & ~lane) | (wdat & lane);
          R_AER:   aer  <= (aer & ~lane) | (wdat & lane);
          R_MODE:  mode <= (mode & ~lane) | (wdat & lane);
          R_VR:    vr   <= din;
          default: ;
        endcase
      end
      if (ack) vec <= {vr[7:IDX_W], hp_vec};
    end
  end
endmodule
